burst_sequencer: RTL

Two-requester sequencer and round-robin arbiter in front of the burst address modifier. It accepts burst requests (start address and stride) from two masters and grants the shared burst datapath to one of them. It then drives the modifier's `burst_en`, `addr_in` and `stride` inputs with a legal waveform: a load cycle, exactly BURST_LEN active cycles, and a mandatory idle gap. This keeps the modifier's burst-length and stride assertions from firing.

---
 rtl/burst_sequencer_if.sv | 38 +++
 rtl/burst_sequencer.sv | 90 +++++++++
 2 files changed

// File: rtl/burst_sequencer_if.sv
// Request/burst bus between the two requesters and the burst sequencer.
// The sequencer connects as the slave; requesters drive the master side.
interface burst_sequencer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int STRIDE_LEN = 4,
    parameter int BURST_LEN  = 8
);
    localparam int CW = $clog2(BURST_LEN) + 1;

    logic [1:0]            req;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [STRIDE_LEN-1:0] req_stride0;
    logic [STRIDE_LEN-1:0] req_stride1;
    logic                  abort;
    logic [1:0]            gnt;
    logic                  owner;
    logic                  busy;
    logic                  burst_en;
    logic [ADDR_WIDTH-1:0] burst_addr;
    logic [STRIDE_LEN-1:0] burst_stride;
    logic [CW-1:0]         beat_cnt;
    logic                  done;
    logic                  aborted;
    logic                  err_stride;

    modport master (
        output req, req_addr0, req_addr1, req_stride0, req_stride1, abort,
        input  gnt, owner, busy, burst_en, burst_addr, burst_stride, beat_cnt,
               done, aborted, err_stride
    );

    modport slave (
        input  req, req_addr0, req_addr1, req_stride0, req_stride1, abort,
        output gnt, owner, busy, burst_en, burst_addr, burst_stride, beat_cnt,
               done, aborted, err_stride
    );
endinterface

// File: rtl/burst_sequencer.sv
// Two-requester round-robin arbiter that sequences the burst modifier through
// a load cycle, BURST_LEN active beats and a mandatory idle gap.
module burst_sequencer #(
    parameter int          ADDR_WIDTH = 8,
    parameter int          STRIDE_LEN = 4,
    parameter int          BURST_LEN  = 8,
    parameter int unsigned ADDR_MAX   = 2**ADDR_WIDTH - 1
) (
    input  logic               clk,
    input  logic               rstn,
    burst_sequencer_if.slave   bus
);
    localparam int            CW   = $clog2(BURST_LEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, LOAD, BURST, GAP} state_t;

    state_t                state;
    logic                  prio;
    logic                  any_req;
    logic                  pick;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [STRIDE_LEN-1:0] sel_stride;
    logic                  stride_bad;

    // A lone requester wins outright; prio only breaks ties.
    assign any_req    = |bus.req;
    assign pick       = (&bus.req) ? prio : bus.req[1];
    assign sel_addr   = pick ? bus.req_addr1 : bus.req_addr0;
    assign sel_stride = pick ? bus.req_stride1 : bus.req_stride0;
    assign stride_bad = 64'(sel_stride) > 64'(ADDR_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state            <= IDLE;
            prio             <= 1'b0;
            bus.gnt          <= '0;
            bus.owner        <= 1'b0;
            bus.busy         <= 1'b0;
            bus.burst_en     <= 1'b0;
            bus.burst_addr   <= '0;
            bus.burst_stride <= '0;
            bus.beat_cnt     <= '0;
            bus.done         <= 1'b0;
            bus.aborted      <= 1'b0;
            bus.err_stride   <= 1'b0;
        end else begin
            bus.gnt     <= '0;
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    bus.burst_en <= 1'b0;
                    bus.beat_cnt <= '0;
                    if (any_req) begin
                        state            <= LOAD;
                        bus.gnt          <= pick ? 2'b10 : 2'b01;
                        bus.owner        <= pick;
                        prio             <= ~pick;
                        bus.burst_addr   <= sel_addr;
                        bus.burst_stride <= sel_stride;
                        bus.busy         <= 1'b1;
                        if (stride_bad)
                            bus.err_stride <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                LOAD: begin
                    state        <= BURST;
                    bus.burst_en <= 1'b1;
                    bus.beat_cnt <= CW'(1);
                end
                BURST: begin
                    // beat_cnt freezes here so GAP reports how many beats went out.
                    if (bus.beat_cnt == LAST || bus.abort) begin
                        state        <= GAP;
                        bus.burst_en <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.aborted  <= (bus.beat_cnt != LAST);
                    end else begin
                        bus.beat_cnt <= bus.beat_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
